// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_arbiter
// Round-robin arbiter/sequencer sharing one UART transmitter among NUM_REQ clients.
// Rev    : 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_BITS    = 8,
  parameter int START_CYCLES = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                           SysClk,
  input  logic                           Rst,
  input  logic                           Enable,
  input  logic [NUM_REQ-1:0]             Req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   Req_Data,
  output logic [NUM_REQ-1:0]             Grant,
  output logic [NUM_REQ-1:0]             Done,
  output logic [DATA_BITS-1:0]           Tx_Data,
  output logic                           Transmit_Start,
  input  logic                           Tx_Busy,
  input  logic                           BIST_Busy,
  output logic                           Active,
  output logic                           Timeout_Err,
  output logic [$clog2(NUM_REQ)-1:0]     Err_Id
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int SUM_W   = IDX_W + 1;
  localparam int CNT_MAX = (START_CYCLES > BUSY_TIMEOUT) ? START_CYCLES : BUSY_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   c_START_LAST = CNT_W'(START_CYCLES);
  localparam logic [CNT_W-1:0]   c_BUSY_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   c_CNT_ONE    = CNT_W'(1);
  localparam logic [SUM_W-1:0]   c_NUM_REQ    = SUM_W'(NUM_REQ);
  localparam logic [IDX_W-1:0]   c_LAST_IDX   = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0]   c_IDX_ONE    = IDX_W'(1);
  localparam logic [NUM_REQ-1:0] c_ONE_HOT0   = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                 state_q;
  logic [IDX_W-1:0]       ptr_q;
  logic [IDX_W-1:0]       ptr_d;
  logic [IDX_W-1:0]       cur_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [NUM_REQ-1:0]     grant_q;
  logic [NUM_REQ-1:0]     done_q;
  logic [DATA_BITS-1:0]   tx_data_q;
  logic                   start_q;
  logic                   active_q;
  logic                   timeout_q;
  logic [IDX_W-1:0]       err_id_q;

  logic [SUM_W-1:0]       rot_idx;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_vld;

  // Scan from the highest offset down so the lowest offset from ptr_q wins.
  always_comb begin
    rot_idx = '0;
    win_idx = '0;
    win_vld = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      rot_idx = {1'b0, ptr_q} + SUM_W'(i);
      if (rot_idx >= c_NUM_REQ) begin
        rot_idx = rot_idx - c_NUM_REQ;
      end
      if (Req[rot_idx[IDX_W-1:0]]) begin
        win_idx = rot_idx[IDX_W-1:0];
        win_vld = 1'b1;
      end
    end
  end

  assign ptr_d = (win_idx == c_LAST_IDX) ? '0 : win_idx + c_IDX_ONE;

  always_ff @(posedge SysClk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cur_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      tx_data_q <= '0;
      start_q   <= 1'b0;
      active_q  <= 1'b0;
      timeout_q <= 1'b0;
      err_id_q  <= '0;
    end else begin
      grant_q   <= '0;
      done_q    <= '0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Enable && !BIST_Busy && win_vld) begin
            state_q   <= START;
            active_q  <= 1'b1;
            grant_q   <= c_ONE_HOT0 << win_idx;
            tx_data_q <= Req_Data[win_idx*DATA_BITS +: DATA_BITS];
            cur_q     <= win_idx;
            ptr_q     <= ptr_d;
            cnt_q     <= '0;
          end
        end
        START: begin
          // The grant cycle is spent here with the strobe still low.
          if (cnt_q == c_START_LAST) begin
            start_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= WAIT_BUSY;
          end else begin
            start_q <= 1'b1;
            cnt_q   <= cnt_q + c_CNT_ONE;
          end
        end
        WAIT_BUSY: begin
          if (Tx_Busy) begin
            state_q <= WAIT_DONE;
          end else if (cnt_q == c_BUSY_LAST) begin
            timeout_q <= 1'b1;
            err_id_q  <= cur_q;
            state_q   <= IDLE;
            active_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + c_CNT_ONE;
          end
        end
        WAIT_DONE: begin
          if (!Tx_Busy) begin
            done_q   <= c_ONE_HOT0 << cur_q;
            state_q  <= IDLE;
            active_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          active_q <= 1'b0;
          start_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Grant          = grant_q;
  assign Done           = done_q;
  assign Tx_Data        = tx_data_q;
  assign Transmit_Start = start_q;
  assign Active         = active_q;
  assign Timeout_Err    = timeout_q;
  assign Err_Id         = err_id_q;

endmodule
`default_nettype wire
